// File: rtl/vga_scan_ctrl_if.sv
// vga_scan_ctrl_if: CPU write request and framebuffer write port bundle.
// master drives the CPU request; slave is the scan controller/arbiter.
interface vga_scan_ctrl_if;
    logic        cpu_sel;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_din;
    logic        fb_sel;
    logic        fb_we;
    logic [31:0] fb_addr;
    logic [31:0] fb_din;

    modport master (
        output cpu_sel, cpu_we, cpu_addr, cpu_din,
        input  fb_sel, fb_we, fb_addr, fb_din
    );

    modport slave (
        input  cpu_sel, cpu_we, cpu_addr, cpu_din,
        output fb_sel, fb_we, fb_addr, fb_din
    );
endinterface

// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl: VGA scan timing, pixel realignment and framebuffer write arbiter.
// Hardware clear engine is built only when VGA_SCAN_CLEAR_EN is defined.
module vga_scan_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic          clock,
    input  logic          reset,
    output logic [9:0]    h_addr,
    output logic [9:0]    v_addr,
    input  logic [11:0]   fb_data,
    output logic [3:0]    vga_r,
    output logic [3:0]    vga_g,
    output logic [3:0]    vga_b,
    output logic          vga_hs,
    output logic          vga_vs,
    output logic          vga_valid,
    output logic          vblank,
    output logic          frame_start,
    vga_scan_ctrl_if.slave bus,
    input  logic          clear_start,
    input  logic [11:0]   clear_color,
    output logic          clear_busy
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [9:0] r_h_cnt;
    logic [9:0] r_v_cnt;
    logic       r_hs;
    logic       r_vs;
    logic       r_valid;
    logic       w_active;
    logic       w_hs_n;
    logic       w_vs_n;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == H_LAST) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 10'd1;
        end else begin
            r_h_cnt <= r_h_cnt + 10'd1;
        end
    end

    assign w_active    = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
    assign w_hs_n      = !((r_h_cnt >= HS_BEG) && (r_h_cnt <= HS_END));
    assign w_vs_n      = !((r_v_cnt >= VS_BEG) && (r_v_cnt <= VS_END));
    assign h_addr      = w_active ? r_h_cnt : 10'd0;
    assign v_addr      = w_active ? r_v_cnt : 10'd0;
    assign vblank      = (r_v_cnt >= V_ACT);
    assign frame_start = (r_h_cnt == 10'd0) && (r_v_cnt == 10'd0);

    // Syncs are delayed one cycle to line up with the RAM read latency
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_hs    <= 1'b1;
            r_vs    <= 1'b1;
            r_valid <= 1'b0;
        end else begin
            r_hs    <= w_hs_n;
            r_vs    <= w_vs_n;
            r_valid <= w_active;
        end
    end

    assign vga_hs    = r_hs;
    assign vga_vs    = r_vs;
    assign vga_valid = r_valid;
    assign vga_r     = r_valid ? fb_data[11:8] : 4'd0;
    assign vga_g     = r_valid ? fb_data[7:4]  : 4'd0;
    assign vga_b     = r_valid ? fb_data[3:0]  : 4'd0;

`ifdef VGA_SCAN_CLEAR_EN
    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    localparam logic [9:0] CX_LAST = 10'(H_ACTIVE - 1);
    localparam logic [8:0] CY_LAST = 9'(V_ACTIVE - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [9:0] r_cx;
    logic [9:0] w_cx_nxt;
    logic [8:0] r_cy;
    logic [8:0] w_cy_nxt;
    logic       w_cpu_wr;
    logic       w_grant;

    assign w_cpu_wr   = bus.cpu_sel & bus.cpu_we;
    assign clear_busy = (r_state == S_RUN);
    assign w_grant    = clear_busy && !w_cpu_wr;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cx    <= '0;
            r_cy    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cx    <= w_cx_nxt;
            r_cy    <= w_cy_nxt;
        end
    end

    // Column-major walk: cy runs down a column, then cx steps right
    always_comb begin
        w_state_nxt = r_state;
        w_cx_nxt    = r_cx;
        w_cy_nxt    = r_cy;
        unique case (r_state)
            S_IDLE: begin
                if (clear_start) begin
                    w_state_nxt = S_RUN;
                    w_cx_nxt    = '0;
                    w_cy_nxt    = '0;
                end
            end
            S_RUN: begin
                if (w_grant) begin
                    if (r_cy == CY_LAST) begin
                        w_cy_nxt = '0;
                        if (r_cx == CX_LAST) begin
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_cx_nxt = r_cx + 10'd1;
                        end
                    end else begin
                        w_cy_nxt = r_cy + 9'd1;
                    end
                end
            end
        endcase
    end

    always_comb begin
        bus.fb_sel  = bus.cpu_sel;
        bus.fb_we   = 1'b0;
        bus.fb_addr = bus.cpu_addr;
        bus.fb_din  = bus.cpu_din;
        if (w_cpu_wr) begin
            bus.fb_we = 1'b1;
        end else if (clear_busy) begin
            bus.fb_sel  = 1'b1;
            bus.fb_we   = 1'b1;
            bus.fb_addr = {12'b0, r_cx, r_cy, 1'b0};
            bus.fb_din  = {20'b0, clear_color};
        end
    end
`else
    logic w_unused_clear;

    assign w_unused_clear = ^{clear_start, clear_color};
    assign clear_busy     = 1'b0;
    assign bus.fb_sel     = bus.cpu_sel;
    assign bus.fb_we      = bus.cpu_we;
    assign bus.fb_addr    = bus.cpu_addr;
    assign bus.fb_din     = bus.cpu_din;
`endif

endmodule
